mips_multicycle_controller: RTL and testbench

//  Control FSM for the multicycle MIPS datapath. Replaces the single-cycle ControlUnit
//  (MainDecoder + AluDecoder) so that the processor can share one unified memory for

---
 rtl/mips_multicycle_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/
// writeback over one shared memory, drives all mux selects and enables, counts retirements.
module mips_multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             irwrite,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic op_supported(input logic [5:0] o);
        case (o)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic funct_supported(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    state_t state, state_next;
    logic   pcwrite;
    logic   branch;
    logic   retire;
    logic   decode_bad;

    assign decode_bad = !op_supported(op) || ((op == OP_RTYPE) && !funct_supported(funct));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= state_next;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state)
            FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = mem_ready;
                pcwrite    = mem_ready;
                if (mem_ready)
                    state_next = DECODE;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                if (decode_bad) begin
                    illegal    = 1'b1;
                    state_next = FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_next = MEMADR;
                        OP_RTYPE:     state_next = RTYPEEX;
                        OP_BEQ:       state_next = BEQEX;
                        OP_ADDI:      state_next = ADDIEX;
                        OP_J:         state_next = JEX;
                        default:      state_next = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready)
                    state_next = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                // The strobe stays up across the stall; the memory commits once, on mem_ready.
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_to_alu(funct);
                state_next = RTYPEWB;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // Reset abandons any instruction in flight: no writes, selects parked on FETCH.
        if (reset) begin
            iord       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            memtoreg   = 1'b0;
            regdst     = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b01;
            alucontrol = ALU_ADD;
            pcsrc      = 2'b00;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            illegal    = 1'b0;
            retire     = 1'b0;
        end

        pcen = pcwrite | (branch & zero);
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: walks each instruction class cycle by cycle
// and compares the packed control outputs and the retired counter against hand-built vectors.
module tb_mips_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0]  alusrcb;
    logic [2:0]  alucontrol;
    logic [1:0]  pcsrc;
    logic        pcen, illegal;
    logic [31:0] retired;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_ret    = 0;

    // {iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal}
    logic [15:0] outs;
    assign outs = {iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca,
                   alusrcb, alucontrol, pcsrc, pcen, illegal};

    localparam logic [15:0] E_FR   = {7'b0100000, 2'b01, 3'b010, 2'b00, 1'b1, 1'b0};
    localparam logic [15:0] E_FW   = {7'b0000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_DEC  = {7'b0000000, 2'b11, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_DECI = {7'b0000000, 2'b11, 3'b010, 2'b00, 1'b0, 1'b1};
    localparam logic [15:0] E_MADR = {7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_MRD  = {7'b1000000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_MWB  = {7'b0001010, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_MWR  = {7'b1010000, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_RWB  = {7'b0000110, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_AEX  = {7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_AWB  = {7'b0000010, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
    localparam logic [15:0] E_JEX  = {7'b0000000, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0};
    localparam logic [15:0] E_BEQ0 = {7'b0000001, 2'b00, 3'b110, 2'b01, 1'b0, 1'b0};
    localparam logic [15:0] E_BEQ1 = {7'b0000001, 2'b00, 3'b110, 2'b01, 1'b1, 1'b0};

    mips_multicycle_controller #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        #1;
        compared++;
        if (outs !== E_FW) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b want %b", outs, E_FW);
        end
        compared++;
        if (retired !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_retired: got %0d want 0", retired);
        end
        reset     = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            compared++;
            if (outs !== E_FW) begin
                mismatched++;
                $display("FAIL fetch_hold cycle %0d: got %b want %b", i, outs, E_FW);
            end
            tick();
        end
    endtask

    task automatic test_lw();
        logic [15:0] ex [5] = '{E_FR, E_DEC, E_MADR, E_MRD, E_MWB};
        op = 6'b100011; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            compared++;
            if (outs !== ex[i]) begin
                mismatched++;
                $display("FAIL lw cycle %0d: got %b want %b", i, outs, ex[i]);
            end
            compared++;
            if (retired !== exp_ret) begin
                mismatched++;
                $display("FAIL lw_retired cycle %0d: got %0d want %0d", i, retired, exp_ret);
            end
            tick();
        end
        exp_ret++;
    endtask

    task automatic test_lw_stall();
        logic        mr [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] ex [7] = '{E_FW, E_FR, E_DEC, E_MADR, E_MRD, E_MRD, E_MWB};
        op = 6'b100011; zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            #1;
            compared++;
            if (outs !== ex[i]) begin
                mismatched++;
                $display("FAIL lw_stall cycle %0d: got %b want %b", i, outs, ex[i]);
            end
            compared++;
            if (retired !== exp_ret) begin
                mismatched++;
                $display("FAIL lw_stall_retired cycle %0d: got %0d want %0d", i, retired, exp_ret);
            end
            tick();
        end
        exp_ret++;
    endtask

    task automatic test_sw_stall();
        logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ex [7] = '{E_FR, E_DEC, E_MADR, E_MWR, E_MWR, E_MWR, E_MWR};
        op = 6'b101011; zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            #1;
            compared++;
            if (outs !== ex[i]) begin
                mismatched++;
                $display("FAIL sw cycle %0d: got %b want %b", i, outs, ex[i]);
            end
            compared++;
            if (retired !== exp_ret) begin
                mismatched++;
                $display("FAIL sw_retired cycle %0d: got %0d want %0d", i, retired, exp_ret);
            end
            tick();
        end
        exp_ret++;
    endtask

    task automatic test_beq();
        logic        zt [3] = '{1'b0, 1'b1, 1'b1};
        logic        zn [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] et [3] = '{E_FR, E_DEC, E_BEQ1};
        logic [15:0] en [3] = '{E_FR, E_DEC, E_BEQ0};
        op = 6'b000100; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                zero = (k == 0) ? zt[i] : zn[i];
                #1;
                compared++;
                if (outs !== ((k == 0) ? et[i] : en[i])) begin
                    mismatched++;
                    $display("FAIL beq taken=%0d cycle %0d: got %b want %b", 1 - k, i, outs,
                             (k == 0) ? et[i] : en[i]);
                end
                compared++;
                if (retired !== exp_ret) begin
                    mismatched++;
                    $display("FAIL beq_retired cycle %0d: got %0d want %0d", i, retired, exp_ret);
                end
                tick();
            end
            exp_ret++;
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] al [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [15:0] ex [4];
        op = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            funct = fn[k];
            ex = '{E_FR, E_DEC, {7'b0000001, 2'b00, al[k], 2'b00, 1'b0, 1'b0}, E_RWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                compared++;
                if (outs !== ex[i]) begin
                    mismatched++;
                    $display("FAIL rtype funct=%b cycle %0d: got %b want %b", fn[k], i, outs, ex[i]);
                end
                compared++;
                if (retired !== exp_ret) begin
                    mismatched++;
                    $display("FAIL rtype_retired cycle %0d: got %0d want %0d", i, retired, exp_ret);
                end
                tick();
            end
            exp_ret++;
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2] = '{6'b000000, 6'b111111};
        logic [15:0] ex [3] = '{E_FR, E_DECI, E_FR};
        funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            for (int i = 0; i < 3; i++) begin
                #1;
                compared++;
                if (outs !== ex[i]) begin
                    mismatched++;
                    $display("FAIL illegal op=%b cycle %0d: got %b want %b", ops[k], i, outs, ex[i]);
                end
                compared++;
                if (retired !== exp_ret) begin
                    mismatched++;
                    $display("FAIL illegal_retired cycle %0d: got %0d want %0d", i, retired, exp_ret);
                end
                if (i < 2)
                    tick();
            end
            // Third sample was the next FETCH; hold it so the following pass starts there.
            mem_ready = 1'b0;
            tick();
            mem_ready = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops [7] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
                                 6'b000010, 6'b000010, 6'b000010};
        logic [15:0] ex  [7] = '{E_FR, E_DEC, E_AEX, E_AWB, E_FR, E_DEC, E_JEX};
        logic [31:0] rbase;
        rbase = exp_ret;
        funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            op = ops[i];
            #1;
            compared++;
            if (outs !== ex[i]) begin
                mismatched++;
                $display("FAIL addi_j cycle %0d: got %b want %b", i, outs, ex[i]);
            end
            compared++;
            if (retired !== ((i < 4) ? rbase : rbase + 32'd1)) begin
                mismatched++;
                $display("FAIL addi_j_retired cycle %0d: got %0d want %0d", i, retired,
                         (i < 4) ? rbase : rbase + 32'd1);
            end
            tick();
        end
        exp_ret = rbase + 32'd2;
    endtask

    task automatic test_reset_mid();
        logic        mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] ex [4] = '{E_FR, E_DEC, E_MADR, E_MWR};
        op = 6'b101011; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            #1;
            compared++;
            if (outs !== ex[i]) begin
                mismatched++;
                $display("FAIL reset_mid cycle %0d: got %b want %b", i, outs, ex[i]);
            end
            if (i < 3)
                tick();
        end
        reset = 1'b1;
        #1;
        compared++;
        if (outs !== E_FW) begin
            mismatched++;
            $display("FAIL reset_mid_forced: got %b want %b", outs, E_FW);
        end
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        exp_ret   = 32'd0;
        #1;
        compared++;
        if (outs !== E_FW) begin
            mismatched++;
            $display("FAIL reset_mid_after: got %b want %b", outs, E_FW);
        end
        compared++;
        if (retired !== exp_ret) begin
            mismatched++;
            $display("FAIL reset_mid_retired: got %0d want 0", retired);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        compared++;
        if (outs !== E_FR) begin
            mismatched++;
            $display("FAIL reset_mid_refetch: got %b want %b", outs, E_FR);
        end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) tick();
        test_reset();
        test_lw();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_rtype();
        test_illegal();
        test_back_to_back();
        compared++;
        if (retired !== exp_ret) begin
            mismatched++;
            $display("FAIL retired_total: got %0d want %0d", retired, exp_ret);
        end
        test_reset_mid();
        compared++;
        if (retired !== 32'd0) begin
            mismatched++;
            $display("FAIL retired_final: got %0d want 0", retired);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
